rr_arb_ctrl: RTL and testbench
==============================

# rr_arb_ctrl

Registered round-robin arbiter for sharing one resource among `nbits` requesters. Each request line is a level that stays high while the requester wants the resource. The block grants exactly one requester at a time and holds the grant until that requester releases or a fairness limit expires. It publishes the grant both one-hot and as a binary index, using the same index encoding as the codebase's parameterized one-hot encoder, so downstream muxes can steer directly from `grant_idx`.

## Interface
- `nbits`, 8, number of requesters; legal range 2..32.
- `hold_max`, 4, maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..255.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  reset, asynchronous and active-low (0 asserts).
- `req`  input  nbits  request levels; bit i is requester i.
- `grant`  output  nbits  registered one-hot grant, or all zeros when no owner.
- `grant_idx`  output  $clog2(nbits)  binary index of the set `grant` bit; 0 when `grant` is 0.
- `grant_val`  output  1  equals `|grant`.

## Operation
- State:
  - `grant` register (nbits).
  - priority pointer `ptr` (index 0..nbits-1).
  - hold counter `cnt` (8 bits).
- Selection `sel` (combinational): the first index i, searching ptr, ptr+1, …, nbits-1, 0, …, ptr-1, with `req[i]`=1. `any` = |req.
- Let g be the current owner index and `others` = |(req & ~grant).
- Next-state rules at the rising edge, first match wins:
  - **IDLE** (`grant`=0), `any`=1: grant <= onehot(sel); ptr <= (sel+1) mod nbits; cnt <= 1.
  - **IDLE**, `any`=0: hold all state.
  - **OWNED**, `req[g]`=0 (release): if `any`=1, perform a new grant exactly as IDLE does. Otherwise grant <= 0 and cnt <= 0; ptr is unchanged.
  - **OWNED**, `req[g]`=1, cnt==hold_max and `others`=1 (preempt): grant <= onehot(sel); ptr <= (sel+1) mod nbits; cnt <= 1. Because ptr = g+1, g is searched last, so sel ≠ g.
  - **OWNED**, otherwise (keep): grant unchanged; cnt <= min(cnt+1, hold_max). When no competitor exists, the owner keeps the grant indefinitely.
- `grant_idx` and `grant_val` are derived combinationally from the `grant` register, so all outputs change only at clock edges or on reset.
- Invariant: `grant` is always zero or one-hot. The bench checks this every cycle.
- `ptr` wrap: ptr = nbits-1 followed by a grant advances ptr to 0.

## Timing
- **Reset.** While `reset`=0, asynchronously: grant=0, grant_idx=0, grant_val=0, ptr=0, cnt=0. The first grant may occur at the first rising edge after deassertion.
- **Reset mid-operation.** An assertion during an active grant drops the grant immediately, without waiting for a clock edge.
- **Grant latency.** A req rising before edge N in IDLE produces a grant visible after edge N, i.e. 1 cycle.
- **Release latency.** When the owner drops req before edge N, the grant leaves the owner at edge N. A waiting requester is granted at the same edge, with no idle bubble.
- **Simultaneous events.** Release and new requests arriving at the same edge are resolved by a single `sel` from the current ptr. A preempted owner that keeps req high re-enters the rotation normally.
- **Hold accounting.** The owner holds at most hold_max edges while `others`=1. With hold_max=1, the grant rotates every cycle among persistent requesters.
- **Output glitches.** No combinational path from `req` to any output.

## Test plan
- **Reset.** Assert reset low mid-grant while req=8'hFF.
  - Outputs go 0 immediately.
  - After release, req=8'h01 → grant=8'h01, grant_idx=0 one edge later.
- **Single requester.** req=8'h10 held for 10 cycles.
  - grant=8'h10 and grant_idx=4 from cycle 1 onward, never preempted.
  - Dropping req → grant=0, grant_val=0 next edge.
- **Round-robin release.** req=8'h85 with each owner releasing after 1 cycle of ownership.
  - Grant order 0, 2, 7; then back to 0 if req[0] is reasserted.
  - Covers ptr wrap.
- **Preemption (hold_max=4).** req=8'h03 held constantly.
  - grant=8'h01 for 4 cycles, then 8'h02 for 4 cycles, then 8'h01 again.
- **Zero-bubble handoff.** Owner 3 drops req at the same edge requester 5 raises req.
  - grant goes 8'h08 → 8'h20 on that edge; grant_val stays 1.
- **Parameter sweep.** nbits=10, hold_max=1, req=10'h3FF.
  - grant_idx cycles 0..9 then wraps to 0, one step per cycle.
- **Invariant check.** For all scenarios above, check every cycle that `grant` is zero or one-hot.

Source files
------------

// File: rtl/rr_arb_ctrl.sv
// Registered round-robin arbiter: one owner at a time, held until release or until the
// hold limit expires while others wait. Grant is published one-hot and as a binary index.
module rr_arb_ctrl #(
    parameter int unsigned nbits    = 8,
    parameter int unsigned hold_max = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [nbits-1:0]         req,
    output logic [nbits-1:0]         grant,
    output logic [$clog2(nbits)-1:0] grant_idx,
    output logic                     grant_val
);

    localparam int unsigned IdxW = $clog2(nbits);
    localparam int unsigned SumW = IdxW + 1;
    localparam logic [SumW-1:0] NbitsW  = SumW'(nbits);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(nbits - 1);
    localparam logic [7:0]      HoldMax = 8'(hold_max);

    logic [nbits-1:0] grant_q, grant_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [2*nbits-1:0] req_dbl;
    logic [nbits-1:0]   req_rot;
    logic [IdxW-1:0]    off;
    logic [SumW-1:0]    sel_sum;
    logic [IdxW-1:0]    sel;
    logic [IdxW-1:0]    sel_next;
    logic               any_req;
    logic               owner_req;
    logic               others;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[nbits-1:0];
        off     = '0;
        for (int k = nbits - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = IdxW'(k);
            end
        end
        sel_sum = {1'b0, ptr_q} + {1'b0, off};
        if (sel_sum >= NbitsW) begin
            sel_sum = sel_sum - NbitsW;
        end
        sel      = sel_sum[IdxW-1:0];
        sel_next = (sel == LastIdx) ? '0 : sel + 1'b1;
    end

    assign any_req   = |req;
    assign owner_req = |(req & grant_q);
    assign others    = |(req & ~grant_q);

    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (grant_q == '0 || !owner_req) begin
            if (any_req) begin
                grant_d = nbits'(1) << sel;
                ptr_d   = sel_next;
                cnt_d   = 8'd1;
            end else if (grant_q != '0) begin
                grant_d = '0;
                cnt_d   = 8'd0;
            end
        end else if (cnt_q == HoldMax && others) begin
            // Pointer sits just past the owner, so sel always lands on a competitor.
            grant_d = nbits'(1) << sel;
            ptr_d   = sel_next;
            cnt_d   = 8'd1;
        end else begin
            cnt_d = (cnt_q >= HoldMax) ? HoldMax : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (grant_q[i]) begin
                grant_idx = grant_idx | IdxW'(i);
            end
        end
    end

    assign grant     = grant_q;
    assign grant_val = |grant_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Scoreboard bench for rr_arb_ctrl: an 8-requester/hold-4 instance for the main scenarios
// and a 10-requester/hold-1 instance for the rotation sweep.
module tb_rr_arb_ctrl;

    typedef struct {
        string      name;
        logic [9:0] g;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req1 = '0;
    logic [9:0] req2 = '0;
    logic [7:0] grant1;
    logic [2:0] idx1;
    logic       val1;
    logic [9:0] grant2;
    logic [3:0] idx2;
    logic       val2;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arb_ctrl #(.nbits(8), .hold_max(4)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req1),
        .grant     (grant1),
        .grant_idx (idx1),
        .grant_val (val1)
    );

    rr_arb_ctrl #(.nbits(10), .hold_max(1)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req2),
        .grant     (grant2),
        .grant_idx (idx2),
        .grant_val (val2)
    );

    function automatic int idx_of(logic [9:0] g);
        for (int i = 0; i < 10; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply1(string name, logic [7:0] r, logic [7:0] g);
        @(negedge clk);
        req1 = r;
        q1.push_back('{name, {2'b00, g}});
    endtask

    task automatic apply2(string name, logic [9:0] r, logic [9:0] g);
        @(negedge clk);
        req2 = r;
        q2.push_back('{name, g});
    endtask

    // Assert reset between edges and confirm outputs drop without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        cmp("rst_grant8", 32'(grant1), 32'd0);
        cmp("rst_idx8", 32'(idx1), 32'd0);
        cmp("rst_val8", 32'(val1), 32'd0);
        cmp("rst_grant10", 32'(grant2), 32'd0);
        req1 = '0;
        req2 = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp({e.name, "_grant"}, 32'(grant1), 32'(e.g[7:0]));
                cmp({e.name, "_idx"}, 32'(idx1), 32'(idx_of(e.g)));
                cmp({e.name, "_val"}, 32'(val1), 32'(|e.g));
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp({e.name, "_grant"}, 32'(grant2), 32'(e.g));
                cmp({e.name, "_idx"}, 32'(idx2), 32'(idx_of(e.g)));
                cmp({e.name, "_val"}, 32'(val2), 32'(|e.g));
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            cmp("onehot8", 32'($onehot0(grant1)), 32'd1);
            cmp("onehot10", 32'($onehot0(grant2)), 32'd1);
        end
    end

    initial begin : stimulus
        do_reset();

        // Grant under full contention, then reset mid-grant.
        apply1("ff_first", 8'hFF, 8'h01);
        apply1("ff_hold1", 8'hFF, 8'h01);
        apply1("ff_hold2", 8'hFF, 8'h01);
        do_reset();
        apply1("post_reset", 8'h01, 8'h01);

        // Single requester: owner 0 releases, 4 takes over and is never preempted.
        for (int i = 0; i < 10; i++) apply1("single", 8'h10, 8'h10);
        apply1("single_drop", 8'h00, 8'h00);

        // Round-robin release with pointer wrap.
        do_reset();
        apply1("rr_0", 8'h85, 8'h01);
        apply1("rr_2", 8'h84, 8'h04);
        apply1("rr_7", 8'h80, 8'h80);
        apply1("rr_wrap0", 8'h01, 8'h01);
        apply1("rr_idle", 8'h00, 8'h00);

        // Preemption after hold_max=4 edges.
        do_reset();
        for (int i = 0; i < 4; i++) apply1("pre_a", 8'h03, 8'h01);
        for (int i = 0; i < 4; i++) apply1("pre_b", 8'h03, 8'h02);
        apply1("pre_a_again", 8'h03, 8'h01);
        apply1("pre_idle", 8'h00, 8'h00);

        // Zero-bubble handoff 3 -> 5 (ptr is 1 here).
        apply1("zb_own3", 8'h08, 8'h08);
        apply1("zb_hold3", 8'h08, 8'h08);
        apply1("zb_hand5", 8'h20, 8'h20);
        apply1("zb_idle", 8'h00, 8'h00);

        // nbits=10, hold_max=1: rotate every cycle through 0..9 then wrap.
        do_reset();
        for (int i = 0; i < 11; i++) apply2("sweep", 10'h3FF, 10'(1) << (i % 10));
        apply2("sweep_idle", 10'h000, 10'h000);

        for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
        #2;
        cmp("drain_q1", 32'(q1.size()), 32'd0);
        cmp("drain_q2", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
